// File: rtl/lm_sm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer: walks the register mask lowest bit first and issues one memory access per set bit.
// Define LMSM_BASE_WRITEBACK_EN to add the WB state that writes base+count back into ra.
module lm_sm_sequencer (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [7:0]  i_imm_mask,
  input  logic [2:0]  i_ra_addr,
  input  logic [15:0] i_base_addr,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic [2:0]  o_rf_rd_addr,
  input  logic [15:0] i_rf_rd_data,
  output logic        o_rf_wr_en,
  output logic [2:0]  o_rf_wr_addr,
  output logic [15:0] o_rf_wr_data,
  output logic        o_busy,
  output logic        o_done
);

`ifdef LMSM_BASE_WRITEBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB, S_DONE} state_t;
  localparam state_t S_FINISH = S_WB;
  localparam logic   FIN_DONE = 1'b0;
  logic [2:0]  r_ra;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  localparam state_t S_FINISH = S_DONE;
  localparam logic   FIN_DONE = 1'b1;
  logic        w_unused_ra;
  assign w_unused_ra = ^i_ra_addr;
`endif

  state_t      r_state;
  logic [7:0]  r_rem;
  logic [3:0]  r_cnt;
  logic [15:0] r_base;
  logic        r_store;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [2:0]  r_rf_rd_addr;
  logic        r_rf_wr_en;
  logic [2:0]  r_rf_wr_addr;
  logic [15:0] r_rf_wr_data;
  logic        r_busy;
  logic        r_done;

  logic [2:0]  w_idx;
  logic [7:0]  w_rem_clr;
  logic [15:0] w_addr;

  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic found;
    f_lowest = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[i] && !found) begin
        f_lowest = 3'(i);
        found    = 1'b1;
      end
    end
  endfunction

  assign w_idx     = f_lowest(r_rem);
  assign w_rem_clr = r_rem & ~(8'd1 << w_idx);
  assign w_addr    = r_base + {12'b0, r_cnt};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_cnt        <= '0;
      r_base       <= '0;
      r_store      <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_rf_rd_addr <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_addr <= '0;
      r_rf_wr_data <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef LMSM_BASE_WRITEBACK_EN
      r_ra         <= '0;
`endif
    end else begin
      r_rf_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_store <= i_is_store;
            r_rem   <= i_imm_mask;
            r_base  <= i_base_addr;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef LMSM_BASE_WRITEBACK_EN
            r_ra    <= i_ra_addr;
`endif
            if (i_imm_mask == '0) begin
              r_state <= S_FINISH;
              r_done  <= FIN_DONE;
            end else begin
              r_state      <= S_ACCESS;
              r_mem_req    <= 1'b1;
              r_mem_we     <= i_is_store;
              r_mem_addr   <= i_base_addr;
              r_rf_rd_addr <= f_lowest(i_imm_mask);
            end
          end
        end
        S_ACCESS: begin
          if (i_mem_ack) begin
            r_rem <= w_rem_clr;
            r_cnt <= r_cnt + 4'd1;
            if (!r_store) begin
              r_rf_wr_en   <= 1'b1;
              r_rf_wr_addr <= w_idx;
              r_rf_wr_data <= i_mem_rdata;
            end
            // Request/address registers are preloaded for the next transfer so they stay glitch-free outputs.
            if (w_rem_clr == '0) begin
              r_state      <= S_FINISH;
              r_done       <= FIN_DONE;
              r_mem_req    <= 1'b0;
              r_mem_we     <= 1'b0;
              r_mem_addr   <= '0;
              r_rf_rd_addr <= '0;
            end else begin
              r_mem_addr   <= w_addr + 16'd1;
              r_rf_rd_addr <= f_lowest(w_rem_clr);
            end
          end
        end
`ifdef LMSM_BASE_WRITEBACK_EN
        S_WB: begin
          r_rf_wr_en   <= 1'b1;
          r_rf_wr_addr <= r_ra;
          r_rf_wr_data <= w_addr;
          r_state      <= S_DONE;
          r_done       <= 1'b1;
        end
`endif
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = (r_mem_req && r_mem_we) ? i_rf_rd_data : '0;
  assign o_rf_rd_addr = r_rf_rd_addr;
  assign o_rf_wr_en   = r_rf_wr_en;
  assign o_rf_wr_addr = r_rf_wr_addr;
  assign o_rf_wr_data = r_rf_wr_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
